// File: rtl/bus_master_pkg.sv
`default_nettype none
//============================================================================
// Module   : bus_master_pkg
// Brief    : Shared types and constants for the 8088 min-mode bus master.
// Revision : 1.0
//============================================================================
package bus_master_pkg;

    typedef enum logic [2:0] {
        TI         = 3'd0,
        T1         = 3'd1,
        T2         = 3'd2,
        T3         = 3'd3,
        TW         = 3'd4,
        T4         = 3'd5,
        TIDLE_INTA = 3'd6,
        THOLD      = 3'd7
    } bus_state_t;

    typedef enum logic [2:0] {
        MEMR = 3'd0,
        MEMW = 3'd1,
        IOR  = 3'd2,
        IOW  = 3'd3,
        INTA = 3'd4
    } req_type_t;

    localparam logic [7:0] IDLE_DATA = 8'hFF;

    function automatic logic is_legal_type(input logic [2:0] t);
        return (t <= 3'd4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_cycle_master.sv
`default_nettype none
//============================================================================
// Module   : bus_cycle_master
// Brief    : Turns single-byte requests into 8088 minimum-mode T1-T4 bus
//            cycles with RDY waits, HOLD/HLDA and double-pulse INTA.
//            Optional TW timeout: define BUS_MASTER_TIMEOUT_EN.
// Revision : 1.0
//============================================================================
module bus_cycle_master
    import bus_master_pkg::*;
#(
    parameter int INTA_IDLE_STATES = 2,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_clock_posedge,
    input  logic        cpu_clock_negedge,
    input  logic        req_valid,
    input  logic [2:0]  req_type,
    input  logic [19:0] req_address,
    input  logic [7:0]  req_data,
    output logic        req_ack,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_timeout,
    output logic [19:0] ADDRESS,
    output logic [7:0]  DATA_OUT,
    input  logic [7:0]  DATA_IN,
    output logic        bus_float,
    input  logic        RDY,
    input  logic        HOLD,
    output logic        HLDA,
    output logic        ALE,
    output logic        RD_N,
    output logic        WR_N,
    output logic        IO_OR_M,
    output logic        DT_OR_R,
    output logic        DEN_N,
    output logic        INTA_N
);

    localparam logic [2:0] C_IDLE_LAST = 3'(INTA_IDLE_STATES - 1);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 ||
        INTA_IDLE_STATES < 0 || INTA_IDLE_STATES > 7) begin : g_bad_cfg
        $error("bus_cycle_master: parameter out of range");
    end

    bus_state_t  state_q, state_d;
    req_type_t   type_q, type_d;
    logic [19:0] address_q, address_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        inta_second_q, inta_second_d;
    logic        last_q, last_d;
    logic [2:0]  idle_cnt_q, idle_cnt_d;
    logic        rdy_q, rdy_d, hold_q, hold_d;
    logic        ale_q, ale_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, inta_n_q, inta_n_d;
    logic        io_or_m_q, io_or_m_d, dt_or_r_q, dt_or_r_d, den_n_q, den_n_d;
    logic        hlda_q, hlda_d, bus_float_q, bus_float_d;
    logic [7:0]  data_out_q, data_out_d, rsp_data_q, rsp_data_d;
    logic        req_ack_q, req_ack_d, rsp_valid_q, rsp_valid_d;
    logic        enter_t4, timed_out;
    logic        is_rd, is_wr, is_inta, is_io;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam logic [8:0] C_TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);
    logic [7:0] tw_cnt_q, tw_cnt_d;
    logic       rsp_timeout_q, rsp_timeout_d;
`endif

    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        address_d     = address_q;
        wdata_d       = wdata_q;
        inta_second_d = inta_second_q;
        last_d        = last_q;
        idle_cnt_d    = idle_cnt_q;
        rdy_d         = cpu_clock_posedge ? RDY  : rdy_q;
        hold_d        = cpu_clock_posedge ? HOLD : hold_q;
        req_ack_d     = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        enter_t4      = 1'b0;
        timed_out     = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
        tw_cnt_d      = tw_cnt_q;
        rsp_timeout_d = 1'b0;
`endif
        if (cpu_clock_negedge) begin
            case (state_q)
                TI: begin
                    if (hold_q) begin
                        state_d = THOLD;
                    end else if (req_valid) begin
                        req_ack_d = 1'b1;
                        if (is_legal_type(req_type)) begin
                            state_d       = T1;
                            type_d        = req_type_t'(req_type);
                            address_d     = (req_type == IOR || req_type == IOW) ?
                                            {4'h0, req_address[15:0]} : req_address;
                            wdata_d       = req_data;
                            inta_second_d = 1'b0;
                        end else begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = IDLE_DATA;
                        end
                    end
                end
                T1: state_d = T2;
                T2: state_d = T3;
                T3: begin
                    if (rdy_q) begin
                        enter_t4 = 1'b1;
                    end else begin
                        state_d = TW;
`ifdef BUS_MASTER_TIMEOUT_EN
                        tw_cnt_d = 8'd0;
`endif
                    end
                end
                TW: begin
                    if (rdy_q) begin
                        enter_t4 = 1'b1;
`ifdef BUS_MASTER_TIMEOUT_EN
                    end else if (({1'b0, tw_cnt_q} + 9'd1) >= C_TIMEOUT_LIM) begin
                        enter_t4  = 1'b1;
                        timed_out = 1'b1;
                    end else begin
                        tw_cnt_d = tw_cnt_q + 8'd1;
`endif
                    end
                end
                T4: begin
                    if (last_q) begin
                        state_d = TI;
                    end else begin
                        inta_second_d = 1'b1;
                        idle_cnt_d    = 3'd0;
                        state_d       = (INTA_IDLE_STATES == 0) ? T1 : TIDLE_INTA;
                    end
                end
                TIDLE_INTA: begin
                    if (idle_cnt_q == C_IDLE_LAST) state_d = T1;
                    else                           idle_cnt_d = idle_cnt_q + 3'd1;
                end
                THOLD: if (!hold_q) state_d = TI;
                default: state_d = TI;
            endcase

            // A timed-out first INTA ends the sequence instead of running pulse two.
            if (enter_t4) begin
                state_d = T4;
                last_d  = !(type_q == INTA && !inta_second_q) || timed_out;
                if (last_d) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = (timed_out || type_q == MEMW || type_q == IOW) ?
                                  IDLE_DATA : DATA_IN;
`ifdef BUS_MASTER_TIMEOUT_EN
                    rsp_timeout_d = timed_out;
`endif
                end
            end
        end
    end

    assign is_wr   = (type_d == MEMW) || (type_d == IOW);
    assign is_rd   = (type_d == MEMR) || (type_d == IOR);
    assign is_inta = (type_d == INTA);
    assign is_io   = (type_d == IOR) || (type_d == IOW) || is_inta;

    // Strobes are decoded from the next state so they register with it.
    always_comb begin
        ale_d       = 1'b0;
        rd_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        inta_n_d    = 1'b1;
        den_n_d     = 1'b1;
        dt_or_r_d   = 1'b1;
        io_or_m_d   = 1'b0;
        bus_float_d = 1'b1;
        hlda_d      = 1'b0;
        data_out_d  = IDLE_DATA;
        case (state_d)
            T1: begin
                ale_d       = 1'b1;
                io_or_m_d   = is_io;
                dt_or_r_d   = is_wr;
                bus_float_d = is_inta;
            end
            T2, T3, TW, T4: begin
                io_or_m_d   = is_io;
                dt_or_r_d   = is_wr;
                bus_float_d = is_inta;
                data_out_d  = is_wr ? wdata_d : IDLE_DATA;
                if (state_d == T4) begin
                    den_n_d = !is_wr;
                end else begin
                    den_n_d  = 1'b0;
                    rd_n_d   = !is_rd;
                    wr_n_d   = !is_wr;
                    inta_n_d = !is_inta;
                end
            end
            TIDLE_INTA: begin
                io_or_m_d = 1'b1;
                dt_or_r_d = 1'b0;
            end
            THOLD:   hlda_d = 1'b1;
            default: hlda_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= TI;
            type_q        <= MEMR;
            address_q     <= 20'h0;
            wdata_q       <= 8'h0;
            inta_second_q <= 1'b0;
            last_q        <= 1'b0;
            idle_cnt_q    <= 3'd0;
            rdy_q         <= 1'b0;
            hold_q        <= 1'b0;
            ale_q         <= 1'b0;
            rd_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
            inta_n_q      <= 1'b1;
            den_n_q       <= 1'b1;
            dt_or_r_q     <= 1'b1;
            io_or_m_q     <= 1'b0;
            bus_float_q   <= 1'b1;
            hlda_q        <= 1'b0;
            data_out_q    <= IDLE_DATA;
            rsp_data_q    <= IDLE_DATA;
            req_ack_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
            tw_cnt_q      <= 8'd0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            address_q     <= address_d;
            wdata_q       <= wdata_d;
            inta_second_q <= inta_second_d;
            last_q        <= last_d;
            idle_cnt_q    <= idle_cnt_d;
            rdy_q         <= rdy_d;
            hold_q        <= hold_d;
            ale_q         <= ale_d;
            rd_n_q        <= rd_n_d;
            wr_n_q        <= wr_n_d;
            inta_n_q      <= inta_n_d;
            den_n_q       <= den_n_d;
            dt_or_r_q     <= dt_or_r_d;
            io_or_m_q     <= io_or_m_d;
            bus_float_q   <= bus_float_d;
            hlda_q        <= hlda_d;
            data_out_q    <= data_out_d;
            rsp_data_q    <= rsp_data_d;
            req_ack_q     <= req_ack_d;
            rsp_valid_q   <= rsp_valid_d;
`ifdef BUS_MASTER_TIMEOUT_EN
            tw_cnt_q      <= tw_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

`ifdef BUS_MASTER_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign ADDRESS   = address_q;
    assign DATA_OUT  = data_out_q;
    assign bus_float = bus_float_q;
    assign HLDA      = hlda_q;
    assign ALE       = ale_q;
    assign RD_N      = rd_n_q;
    assign WR_N      = wr_n_q;
    assign IO_OR_M   = io_or_m_q;
    assign DT_OR_R   = dt_or_r_q;
    assign DEN_N     = den_n_q;
    assign INTA_N    = inta_n_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_master.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : tb_bus_cycle_master
// Brief    : Directed and random bus cycles checked against a cycle-count
//            model of the 8088 min-mode protocol.
// Revision : 1.0
//============================================================================
module tb_bus_cycle_master;
    import bus_master_pkg::*;

    localparam int IDLE_N = 2;
    localparam int TMO    = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  phase = 2'd0;
    logic        cpu_pos, cpu_neg;
    logic        req_valid;
    logic [2:0]  req_type;
    logic [19:0] req_address;
    logic [7:0]  req_data;
    logic        req_ack, rsp_valid, rsp_timeout;
    logic [7:0]  rsp_data;
    logic [19:0] ADDRESS;
    logic [7:0]  DATA_OUT, DATA_IN;
    logic        bus_float, RDY, HOLD, HLDA;
    logic        ALE, RD_N, WR_N, IO_OR_M, DT_OR_R, DEN_N, INTA_N;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) phase <= phase + 2'd1;
    assign cpu_pos = (phase == 2'd0);
    assign cpu_neg = (phase == 2'd2);

    bus_cycle_master #(.INTA_IDLE_STATES(IDLE_N), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .cpu_clock_posedge(cpu_pos), .cpu_clock_negedge(cpu_neg),
        .req_valid(req_valid), .req_type(req_type), .req_address(req_address),
        .req_data(req_data), .req_ack(req_ack), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .ADDRESS(ADDRESS),
        .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN), .bus_float(bus_float),
        .RDY(RDY), .HOLD(HOLD), .HLDA(HLDA), .ALE(ALE), .RD_N(RD_N),
        .WR_N(WR_N), .IO_OR_M(IO_OR_M), .DT_OR_R(DT_OR_R), .DEN_N(DEN_N),
        .INTA_N(INTA_N)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the first sampling point of the next T-state.
    task automatic next_tstate();
        @(negedge clock);
        while (!cpu_neg) @(negedge clock);
        @(negedge clock);
    endtask

    task automatic check_idle_pins(input string tag, input logic exp_reset_regs);
        check({tag, "_ale"},   ALE, 1'b0);
        check({tag, "_strb"},  {RD_N, WR_N, INTA_N, DEN_N, DT_OR_R}, 5'b11111);
        check({tag, "_iom"},   IO_OR_M, 1'b0);
        check({tag, "_float"}, bus_float, 1'b1);
        check({tag, "_hlda"},  HLDA, 1'b0);
        check({tag, "_dout"},  DATA_OUT, 8'hFF);
        if (exp_reset_regs) begin
            check({tag, "_addr"},  ADDRESS, 20'h0);
            check({tag, "_rsp"},   {req_ack, rsp_valid, rsp_timeout}, 3'b000);
            check({tag, "_rdata"}, rsp_data, 8'hFF);
        end
    endtask

    task automatic run_req(input logic [2:0] t, input logic [19:0] a, input logic [7:0] d,
                           input logic [7:0] din, input int w, input bit hold_mid,
                           input bit expect_tmo);
        int ts, ale_c, rd_c, wr_c, inta_c, inta_p, den_c, rsp_c, hlda_c, dout_bad, w_eff;
        logic [7:0]  rdat;
        logic        rtmo, prev_inta, io1, dt1, fl1;
        logic [19:0] ad1;
        bit legal, is_rd, is_wr, is_inta, is_io, got;
        legal   = (t <= 3'd4);
        is_rd   = (t == 3'd0) || (t == 3'd2);
        is_wr   = (t == 3'd1) || (t == 3'd3);
        is_inta = (t == 3'd4);
        is_io   = (t == 3'd2) || (t == 3'd3) || is_inta;
        w_eff   = expect_tmo ? TMO : w;
        ts = 0; ale_c = 0; rd_c = 0; wr_c = 0; inta_c = 0; inta_p = 0; den_c = 0;
        rsp_c = 0; hlda_c = 0; dout_bad = 0; prev_inta = 1'b1;
        rdat = 8'hxx; rtmo = 1'bx; io1 = 1'bx; dt1 = 1'bx; fl1 = 1'bx; ad1 = 20'hx;

        req_type = t; req_address = a; req_data = d;
        DATA_IN = is_inta ? ~din : din;
        RDY = 1'b1; req_valid = 1'b1; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            next_tstate();
            if (req_ack) got = 1;
        end
        check("req_ack", got, 1'b1);
        req_valid = 1'b0;
        if (!got) return;

        if (!legal) begin
            check("rsv_rsp_valid", rsp_valid, 1'b1);
            check("rsv_rsp_data", rsp_data, 8'hFF);
            check("rsv_no_ale", ALE, 1'b0);
            next_tstate();
            check_idle_pins("rsv_ti", 1'b0);
            return;
        end

        for (int i = 0; i < 200; i++) begin
            RDY = !(i >= 2 && i < 2 + w);
            ts++;
            if (i == 0) begin io1 = IO_OR_M; dt1 = DT_OR_R; fl1 = bus_float; ad1 = ADDRESS; end
            if (ALE)     ale_c++;
            if (!RD_N)   rd_c++;
            if (!WR_N)   wr_c++;
            if (!INTA_N) inta_c++;
            if (!DEN_N)  den_c++;
            if (HLDA)    hlda_c++;
            if (!WR_N && DATA_OUT !== d) dout_bad++;
            if (prev_inta && !INTA_N) inta_p++;
            prev_inta = INTA_N;
            if (is_inta && inta_p == 1 && INTA_N) begin
                DATA_IN = din;
                if (hold_mid) HOLD = 1'b1;
            end
            if (rsp_valid) begin
                rsp_c++; rdat = rsp_data; rtmo = rsp_timeout;
                break;
            end
            next_tstate();
        end
        RDY = 1'b1;

        check("tstates", ts, is_inta ? 8 + IDLE_N : 4 + w_eff);
        check("ale_cnt", ale_c, is_inta ? 2 : 1);
        check("rd_low", rd_c, is_rd ? 2 + w_eff : 0);
        check("wr_low", wr_c, is_wr ? 2 + w_eff : 0);
        check("inta_low", inta_c, is_inta ? 4 : 0);
        check("inta_pulses", inta_p, is_inta ? 2 : 0);
        check("den_low", den_c, is_inta ? 4 : (is_wr ? 3 + w_eff : 2 + w_eff));
        check("rsp_count", rsp_c, 1);
        check("rsp_data", rdat, (expect_tmo || is_wr) ? 8'hFF : din);
        check("rsp_timeout", rtmo, expect_tmo);
        check("t1_io_or_m", io1, is_io);
        check("t1_dt_or_r", dt1, is_wr);
        check("t1_float", fl1, is_inta);
        if (!is_inta) check("t1_addr", ad1, is_io ? {4'h0, a[15:0]} : a);
        check("dout_bad", dout_bad, 0);
        check("hlda_in_cycle", hlda_c, 0);
        next_tstate();
        check_idle_pins("post_ti", 1'b0);
    endtask

    initial begin
        int rsp_seen, ack_seen;
        logic [2:0] rt;
        reset = 1'b1; req_valid = 1'b0; req_type = 3'd0; req_address = 20'h0;
        req_data = 8'h0; DATA_IN = 8'h0; RDY = 1'b1; HOLD = 1'b0;
        repeat (3) @(negedge clock);
        check_idle_pins("reset", 1'b1);
        reset = 1'b0;
        next_tstate();
        next_tstate();

        run_req(MEMR, 20'hF0000, 8'h00, 8'h5A, 0, 0, 0);
        run_req(IOW,  20'h00020, 8'h13, 8'hEE, 2, 0, 0);
        run_req(INTA, 20'h00000, 8'h00, 8'h08, 0, 1, 0);
        next_tstate();
        check("hold_after_inta", {HLDA, bus_float}, 2'b11);
        HOLD = 1'b0;
        next_tstate();
        check("hold_release_inta", HLDA, 1'b0);

        // HOLD in TI blocks a pending request until released
        HOLD = 1'b1; req_type = MEMR; req_address = 20'h12345; req_valid = 1'b1;
        ack_seen = 0;
        next_tstate();
        check("hold_hlda", {HLDA, bus_float}, 2'b11);
        for (int i = 0; i < 4; i++) begin
            if (req_ack) ack_seen++;
            next_tstate();
        end
        check("hold_no_ack", ack_seen, 0);
        HOLD = 1'b0;
        next_tstate();
        check("hold_drop", {HLDA, req_ack}, 2'b00);
        run_req(IOR, 20'hABCDE, 8'h00, 8'h77, 1, 0, 0);

        // reset during the TW of a memory write
        req_type = MEMW; req_address = 20'h00400; req_data = 8'hA5;
        RDY = 1'b0; req_valid = 1'b1; ack_seen = 0;
        for (int i = 0; i < 10 && ack_seen == 0; i++) begin
            next_tstate();
            if (req_ack) ack_seen = 1;
        end
        req_valid = 1'b0;
        repeat (3) next_tstate();
        check("tw_wr_low", {WR_N, DEN_N}, 2'b00);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_idle_pins("midrst", 1'b1);
        @(negedge clock);
        reset = 1'b0; RDY = 1'b1; rsp_seen = 0;
        for (int i = 0; i < 6; i++) begin
            next_tstate();
            if (rsp_valid) rsp_seen++;
        end
        check("midrst_no_rsp", rsp_seen, 0);
        run_req(MEMW, 20'h00401, 8'h3C, 8'h00, 0, 0, 0);

        for (int k = 0; k < 12; k++) begin
            rt = 3'($urandom_range(0, 7));
            run_req(rt, 20'($urandom), 8'($urandom), 8'($urandom),
                    (rt == 3'd4) ? 0 : int'($urandom_range(0, 3)), 0, 0);
        end

`ifdef BUS_MASTER_TIMEOUT_EN
        run_req(MEMR, 20'h00010, 8'h00, 8'h42, 1000, 0, 1);
        run_req(MEMR, 20'h00011, 8'h00, 8'h24, 0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
